// File: rtl/tank_shell_if.sv
// Tank-to-shell bus: firing tank state, enemy box and keycode in; shell sprite data and hit pulse out.
// master drives the tank/enemy/key side, slave is the shell stage.
interface tank_shell_if;
  logic [7:0] keycode;
  logic [9:0] TankX;
  logic [9:0] TankY;
  logic [1:0] direction;
  logic [9:0] EnemyX;
  logic [9:0] EnemyY;
  logic [9:0] EnemyS;
  logic [9:0] ShellX;
  logic [9:0] ShellY;
  logic [9:0] ShellS;
  logic       shell_active;
  logic       enemy_hit;

  modport master (
    output keycode, TankX, TankY, direction, EnemyX, EnemyY, EnemyS,
    input  ShellX, ShellY, ShellS, shell_active, enemy_hit
  );

  modport slave (
    input  keycode, TankX, TankY, direction, EnemyX, EnemyY, EnemyS,
    output ShellX, ShellY, ShellS, shell_active, enemy_hit
  );
endinterface

// File: rtl/tank_shell.sv
// Single-shell projectile stage: spawn on fire-key edge, one step per frame, enemy box hit test, refire cooldown.
// Optional macro SHELL_BOUNCE_EN: the first wall contact reflects the shell instead of expiring it.
module tank_shell #(
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter logic [9:0] SHELL_SIZE      = 10'd2,
  parameter logic [9:0] SHELL_STEP      = 10'd4,
  parameter logic [9:0] SPAWN_OFFSET    = 10'd8,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd30,
  parameter logic [9:0] X_MIN           = 10'd1,
  parameter logic [9:0] X_MAX           = 10'd639,
  parameter logic [9:0] Y_MIN           = 10'd1,
  parameter logic [9:0] Y_MAX           = 10'd479
) (
  input logic          frame_clk,
  input logic          Reset,
  tank_shell_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  state_t     state;
  logic [9:0] shell_x;
  logic [9:0] shell_y;
  logic       shell_active;
  logic       enemy_hit;
  logic [7:0] cooldown;
  logic [1:0] dir_latched;
  logic       key_prev;
`ifdef SHELL_BOUNCE_EN
  logic       bounced;
`endif

  function automatic logic [10:0] w11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

  logic fire_key;
  logic fire;
  assign fire_key = (bus.keycode == FIRE_KEY);
  assign fire     = fire_key && !key_prev;

  // Spawn point and field check along the tank's current facing
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic       spawn_ok;
  always_comb begin
    spawn_x  = bus.TankX;
    spawn_y  = bus.TankY;
    spawn_ok = 1'b1;
    case (bus.direction)
      2'b00: begin
        spawn_ok = !(w11(bus.TankX) < w11(X_MIN) + w11(SPAWN_OFFSET) + w11(SHELL_SIZE));
        spawn_x  = bus.TankX - SPAWN_OFFSET;
      end
      2'b01: begin
        spawn_ok = !(w11(bus.TankX) + w11(SPAWN_OFFSET) + w11(SHELL_SIZE) > w11(X_MAX));
        spawn_x  = bus.TankX + SPAWN_OFFSET;
      end
      2'b10: begin
        spawn_ok = !(w11(bus.TankY) + w11(SPAWN_OFFSET) + w11(SHELL_SIZE) > w11(Y_MAX));
        spawn_y  = bus.TankY + SPAWN_OFFSET;
      end
      default: begin
        spawn_ok = !(w11(bus.TankY) < w11(Y_MIN) + w11(SPAWN_OFFSET) + w11(SHELL_SIZE));
        spawn_y  = bus.TankY - SPAWN_OFFSET;
      end
    endcase
  end

  logic signed [10:0] diff_x;
  logic signed [10:0] diff_y;
  logic [10:0]        abs_x;
  logic [10:0]        abs_y;
  logic [10:0]        hit_lim;
  logic               hit_now;
  always_comb begin
    diff_x  = $signed(w11(shell_x)) - $signed(w11(bus.EnemyX));
    diff_y  = $signed(w11(shell_y)) - $signed(w11(bus.EnemyY));
    abs_x   = diff_x[10] ? $unsigned(-diff_x) : $unsigned(diff_x);
    abs_y   = diff_y[10] ? $unsigned(-diff_y) : $unsigned(diff_y);
    hit_lim = w11(SHELL_SIZE) + w11(bus.EnemyS);
    hit_now = (abs_x < hit_lim) && (abs_y < hit_lim);
  end

  // Wall test looks one step ahead so the shell never draws outside the field
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       wall;
  always_comb begin
    next_x = shell_x;
    next_y = shell_y;
    wall   = 1'b0;
    case (dir_latched)
      2'b00: begin
        wall   = w11(shell_x) < w11(X_MIN) + w11(SHELL_STEP) + w11(SHELL_SIZE);
        next_x = shell_x - SHELL_STEP;
      end
      2'b01: begin
        wall   = w11(shell_x) + w11(SHELL_STEP) + w11(SHELL_SIZE) > w11(X_MAX);
        next_x = shell_x + SHELL_STEP;
      end
      2'b10: begin
        wall   = w11(shell_y) + w11(SHELL_STEP) + w11(SHELL_SIZE) > w11(Y_MAX);
        next_y = shell_y + SHELL_STEP;
      end
      default: begin
        wall   = w11(shell_y) < w11(Y_MIN) + w11(SHELL_STEP) + w11(SHELL_SIZE);
        next_y = shell_y - SHELL_STEP;
      end
    endcase
  end

  logic do_bounce;
`ifdef SHELL_BOUNCE_EN
  assign do_bounce = wall && !bounced;
`else
  assign do_bounce = 1'b0;
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      shell_x      <= '0;
      shell_y      <= '0;
      shell_active <= 1'b0;
      enemy_hit    <= 1'b0;
      cooldown     <= '0;
      dir_latched  <= 2'b00;
      key_prev     <= 1'b0;
`ifdef SHELL_BOUNCE_EN
      bounced      <= 1'b0;
`endif
    end else begin
      key_prev  <= fire_key;
      enemy_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            dir_latched <= bus.direction;
            if (spawn_ok) begin
              shell_x      <= spawn_x;
              shell_y      <= spawn_y;
              shell_active <= 1'b1;
              state        <= FLYING;
`ifdef SHELL_BOUNCE_EN
              bounced      <= 1'b0;
`endif
            end
          end
        end
        FLYING: begin
          if (hit_now || (wall && !do_bounce)) begin
            enemy_hit    <= hit_now;
            shell_active <= 1'b0;
            shell_x      <= '0;
            shell_y      <= '0;
            cooldown     <= COOLDOWN_FRAMES;
            state        <= COOLDOWN;
          end else if (do_bounce) begin
            dir_latched <= {dir_latched[1], ~dir_latched[0]};
`ifdef SHELL_BOUNCE_EN
            bounced     <= 1'b1;
`endif
          end else begin
            shell_x <= next_x;
            shell_y <= next_y;
          end
        end
        COOLDOWN: begin
          cooldown <= cooldown - 8'd1;
          if (cooldown == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ShellX       = shell_x;
  assign bus.ShellY       = shell_y;
  assign bus.ShellS       = SHELL_SIZE;
  assign bus.shell_active = shell_active;
  assign bus.enemy_hit    = enemy_hit;

endmodule

// File: tb/tb_tank_shell.sv
// Self-checking bench for tank_shell: directed scenarios plus random frames against a per-frame rule model.
// Build with SHELL_BOUNCE_EN defined to also model and exercise wall bounce.
module tb_tank_shell;

  logic frame_clk;
  logic Reset;
  int   n_cmp;
  int   n_bad;

  tank_shell_if bus ();

  tank_shell dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  logic [21:0] dut_obs;
  assign dut_obs = {bus.ShellX, bus.ShellY, bus.shell_active, bus.enemy_hit};

  // Reference model: shell as a point with an integer velocity vector
  int m_state;
  int m_x, m_y, m_vx, m_vy, m_cd;
  bit m_act, m_hit, m_keyprev, m_bounced;

  function automatic logic [21:0] model_obs();
    logic [9:0] x10, y10;
    x10 = m_x[9:0];
    y10 = m_y[9:0];
    return {x10, y10, m_act, m_hit};
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_cd = 0;
    m_act = 0; m_hit = 0; m_keyprev = 0; m_bounced = 0;
  endtask

  task automatic model_end(input bit was_hit);
    m_x = 0; m_y = 0; m_act = 0; m_hit = was_hit; m_cd = 30; m_state = 2;
  endtask

  task automatic model_edge();
    bit fk, fire, ok, wall, bounce_en;
    int vx, vy, sx, sy, nx, ny, ax, ay, lim;
`ifdef SHELL_BOUNCE_EN
    bounce_en = 1;
`else
    bounce_en = 0;
`endif
    fk = (bus.keycode == 8'h2C);
    fire = fk && !m_keyprev;
    m_keyprev = fk;
    m_hit = 0;
    if (m_state == 0) begin
      if (fire) begin
        vx = 0; vy = 0;
        case (bus.direction)
          2'b00: vx = -1;
          2'b01: vx = 1;
          2'b10: vy = 1;
          default: vy = -1;
        endcase
        sx = int'(bus.TankX) + 8 * vx;
        sy = int'(bus.TankY) + 8 * vy;
        if (vx != 0) ok = (sx - 2 >= 1) && (sx + 2 <= 639);
        else         ok = (sy - 2 >= 1) && (sy + 2 <= 479);
        if (ok) begin
          m_x = sx; m_y = sy; m_vx = vx; m_vy = vy;
          m_act = 1; m_bounced = 0; m_state = 1;
        end
      end
    end else if (m_state == 1) begin
      ax = m_x - int'(bus.EnemyX); if (ax < 0) ax = -ax;
      ay = m_y - int'(bus.EnemyY); if (ay < 0) ay = -ay;
      lim = 2 + int'(bus.EnemyS);
      if (ax < lim && ay < lim) model_end(1);
      else begin
        nx = m_x + 4 * m_vx;
        ny = m_y + 4 * m_vy;
        if (m_vx != 0) wall = (nx - 2 < 1) || (nx + 2 > 639);
        else           wall = (ny - 2 < 1) || (ny + 2 > 479);
        if (wall) begin
          if (bounce_en && !m_bounced) begin
            m_bounced = 1; m_vx = -m_vx; m_vy = -m_vy;
          end else model_end(0);
        end else begin
          m_x = nx; m_y = ny;
        end
      end
    end else begin
      m_cd = m_cd - 1;
      if (m_cd == 0) m_state = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic settle();
    bus.keycode = 8'h00;
    for (int i = 0; i < 400 && m_state != 0; i++) tick();
    tick();
  endtask

  task automatic set_tank(input int tx, input int ty, input logic [1:0] d);
    bus.TankX = 10'(tx); bus.TankY = 10'(ty); bus.direction = d;
  endtask

  task automatic set_enemy(input int ex, input int ey, input int es);
    bus.EnemyX = 10'(ex); bus.EnemyY = 10'(ey); bus.EnemyS = 10'(es);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.keycode = 8'h2C;
    set_tank(160, 240, 2'b01);
    set_enemy(480, 240, 4);
    model_reset();
    @(posedge frame_clk);
    #1;
    n_cmp++;
    if (dut_obs !== 22'd0) begin
      n_bad++; $display("[TB] FAIL reset_outputs got %h want 000000", dut_obs);
    end
    n_cmp++;
    if (bus.ShellS !== 10'd2) begin
      n_bad++; $display("[TB] FAIL shell_size got %0d want 2", bus.ShellS);
    end
    Reset = 1'b0;
    bus.keycode = 8'h00;
  endtask

  task automatic test_hit();
    int hits, x_at_hit, last_x;
    bit prev_hit;
    settle();
    set_tank(160, 240, 2'b01);
    set_enemy(480, 240, 4);
    bus.keycode = 8'h2C;
    tick();
    n_cmp++;
    if (bus.ShellX !== 10'd168 || bus.ShellY !== 10'd240 || bus.shell_active !== 1'b1) begin
      n_bad++; $display("[TB] FAIL hit_spawn got x=%0d y=%0d act=%0b want x=168 y=240 act=1",
                        bus.ShellX, bus.ShellY, bus.shell_active);
    end
    bus.keycode = 8'h00;
    hits = 0; x_at_hit = -1; prev_hit = 0;
    for (int f = 0; f < 120; f++) begin
      last_x = int'(bus.ShellX);
      tick();
      n_cmp++;
      if (dut_obs !== model_obs()) begin
        n_bad++; $display("[TB] FAIL hit_trace f=%0d got %h want %h", f, dut_obs, model_obs());
      end
      if (bus.enemy_hit === 1'b1) begin
        hits++;
        x_at_hit = last_x;
        n_cmp++;
        if (prev_hit || bus.shell_active !== 1'b0) begin
          n_bad++; $display("[TB] FAIL hit_pulse_shape f=%0d prev_hit=%0b act=%0b want 0 0",
                            f, prev_hit, bus.shell_active);
        end
      end
      prev_hit = bus.enemy_hit;
    end
    n_cmp++;
    if (hits != 1) begin
      n_bad++; $display("[TB] FAIL hit_count got %0d want 1", hits);
    end
    n_cmp++;
    if (x_at_hit != 476) begin
      n_bad++; $display("[TB] FAIL hit_position got %0d want 476", x_at_hit);
    end
  endtask

  task automatic test_expire_cooldown();
    int max_x, hits;
    bit expired;
    settle();
    set_tank(600, 240, 2'b01);
    set_enemy(480, 100, 4);
    bus.keycode = 8'h2C;
    tick();
    bus.keycode = 8'h00;
    max_x = 0; hits = 0; expired = 0;
    for (int f = 0; f < 200 && !expired; f++) begin
      tick();
      n_cmp++;
      if (dut_obs !== model_obs()) begin
        n_bad++; $display("[TB] FAIL expire_trace f=%0d got %h want %h", f, dut_obs, model_obs());
      end
      if (int'(bus.ShellX) > max_x) max_x = int'(bus.ShellX);
      if (bus.enemy_hit === 1'b1) hits++;
      if (bus.shell_active !== 1'b1) expired = 1;
    end
    n_cmp++;
    if (!expired || max_x != 636 || hits != 0) begin
      n_bad++; $display("[TB] FAIL expire_run got expired=%0b max_x=%0d hits=%0d want 1 636 0",
                        expired, max_x, hits);
    end
    for (int f = 0; f < 9; f++) tick();
    bus.keycode = 8'h2C;
    tick();
    n_cmp++;
    if (bus.shell_active !== 1'b0 || dut_obs !== model_obs()) begin
      n_bad++; $display("[TB] FAIL cooldown_fire_ignored got act=%0b obs=%h want act=0 obs=%h",
                        bus.shell_active, dut_obs, model_obs());
    end
    bus.keycode = 8'h00;
    for (int f = 0; f < 20; f++) tick();
    bus.keycode = 8'h2C;
    tick();
    n_cmp++;
    if (bus.shell_active !== 1'b1 || bus.ShellX !== 10'd608) begin
      n_bad++; $display("[TB] FAIL refire_after_cooldown got act=%0b x=%0d want act=1 x=608",
                        bus.shell_active, bus.ShellX);
    end
    bus.keycode = 8'h00;
  endtask

  task automatic test_spawn_limits();
    int tx[7]      = '{5, 10, 11, 630, 629, 100, 100};
    int ty[7]      = '{240, 240, 240, 240, 240, 10, 469};
    logic [1:0] td[7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10};
    bit ea[7]      = '{0, 0, 1, 0, 1, 0, 1};
    int ex[7]      = '{0, 0, 3, 0, 637, 0, 100};
    int ey[7]      = '{0, 0, 240, 0, 240, 0, 477};
    set_enemy(50, 450, 1);
    for (int i = 0; i < 7; i++) begin
      settle();
      set_tank(tx[i], ty[i], td[i]);
      bus.keycode = 8'h2C;
      tick();
      n_cmp++;
      if (bus.shell_active !== ea[i] || bus.ShellX !== 10'(ex[i]) || bus.ShellY !== 10'(ey[i])
          || dut_obs !== model_obs()) begin
        n_bad++; $display("[TB] FAIL spawn_limit[%0d] got act=%0b x=%0d y=%0d want act=%0b x=%0d y=%0d",
                          i, bus.shell_active, bus.ShellX, bus.ShellY, ea[i], ex[i], ey[i]);
      end
      bus.keycode = 8'h00;
    end
    settle();
    set_tank(5, 240, 2'b00);
    bus.keycode = 8'h2C;
    tick();
    bus.keycode = 8'h00;
    tick();
    set_tank(100, 240, 2'b00);
    bus.keycode = 8'h2C;
    tick();
    n_cmp++;
    if (bus.shell_active !== 1'b1 || bus.ShellX !== 10'd92) begin
      n_bad++; $display("[TB] FAIL refused_no_cooldown got act=%0b x=%0d want act=1 x=92",
                        bus.shell_active, bus.ShellX);
    end
    bus.keycode = 8'h00;
  endtask

  task automatic test_hold_key();
    int launches;
    logic prev_act;
    settle();
    set_tank(300, 240, 2'b11);
    set_enemy(50, 450, 1);
    bus.keycode = 8'h2C;
    launches = 0;
    prev_act = bus.shell_active;
    for (int f = 0; f < 200; f++) begin
      tick();
      n_cmp++;
      if (dut_obs !== model_obs()) begin
        n_bad++; $display("[TB] FAIL hold_trace f=%0d got %h want %h", f, dut_obs, model_obs());
      end
      if (bus.shell_active === 1'b1 && prev_act !== 1'b1) launches++;
      prev_act = bus.shell_active;
    end
    n_cmp++;
    if (launches != 1) begin
      n_bad++; $display("[TB] FAIL hold_launches got %0d want 1", launches);
    end
    bus.keycode = 8'h00;
    tick();
    bus.keycode = 8'h2C;
    tick();
    n_cmp++;
    if (bus.shell_active !== 1'b1 || bus.ShellY !== 10'd232) begin
      n_bad++; $display("[TB] FAIL repress_fire got act=%0b y=%0d want act=1 y=232",
                        bus.shell_active, bus.ShellY);
    end
    bus.keycode = 8'h00;
  endtask

  task automatic test_async_reset();
    bit reached;
    settle();
    set_tank(100, 240, 2'b01);
    set_enemy(50, 450, 1);
    bus.keycode = 8'h2C;
    tick();
    bus.keycode = 8'h00;
    reached = 0;
    for (int f = 0; f < 100 && !reached; f++) begin
      tick();
      if (bus.ShellX === 10'd300) reached = 1;
    end
    n_cmp++;
    if (!reached) begin
      n_bad++; $display("[TB] FAIL reset_reach300 got x=%0d want 300", bus.ShellX);
    end
    #2 Reset = 1'b1;
    #1;
    n_cmp++;
    if (dut_obs !== 22'd0) begin
      n_bad++; $display("[TB] FAIL async_reset got %h want 000000", dut_obs);
    end
    #1 Reset = 1'b0;
    model_reset();
    bus.keycode = 8'h2C;
    tick();
    n_cmp++;
    if (bus.shell_active !== 1'b1 || bus.ShellX !== 10'd108) begin
      n_bad++; $display("[TB] FAIL fire_after_reset got act=%0b x=%0d want act=1 x=108",
                        bus.shell_active, bus.ShellX);
    end
    bus.keycode = 8'h00;
  endtask

  task automatic test_random();
    bit prev_hit;
    settle();
    prev_hit = 0;
    for (int f = 0; f < 400; f++) begin
      bus.keycode = ($urandom_range(0, 3) == 0) ? 8'h2C : 8'($urandom_range(0, 255));
      set_tank($urandom_range(0, 639), $urandom_range(0, 479), 2'($urandom_range(0, 3)));
      set_enemy($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(1, 60));
      tick();
      n_cmp++;
      if (dut_obs !== model_obs() || (prev_hit && bus.enemy_hit === 1'b1)) begin
        n_bad++; $display("[TB] FAIL random_trace f=%0d got %h want %h prev_hit=%0b",
                          f, dut_obs, model_obs(), prev_hit);
      end
      prev_hit = bus.enemy_hit;
    end
    bus.keycode = 8'h00;
  endtask

`ifdef SHELL_BOUNCE_EN
  task automatic test_bounce();
    int held, last_x;
    bit done;
    settle();
    set_tank(600, 240, 2'b01);
    set_enemy(480, 100, 4);
    bus.keycode = 8'h2C;
    tick();
    bus.keycode = 8'h00;
    held = 0; last_x = 0; done = 0;
    for (int f = 0; f < 400 && !done; f++) begin
      if (bus.ShellX === 10'd636) held++;
      last_x = int'(bus.ShellX);
      tick();
      n_cmp++;
      if (dut_obs !== model_obs()) begin
        n_bad++; $display("[TB] FAIL bounce_trace f=%0d got %h want %h", f, dut_obs, model_obs());
      end
      if (bus.shell_active !== 1'b1) done = 1;
    end
    n_cmp++;
    if (!done || held != 2 || last_x != 4) begin
      n_bad++; $display("[TB] FAIL bounce_run got done=%0b held636=%0d last_x=%0d want 1 2 4",
                        done, held, last_x);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_hit();
    test_expire_cooldown();
    test_spawn_limits();
    test_hold_key();
    test_async_reset();
`ifdef SHELL_BOUNCE_EN
    test_bounce();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
